// File: rtl/operand_fetch.sv
// Operand-fetch stage: issues register-file reads, captures the data a cycle later,
// forwards from EX/MEM/WB and stalls on load-use hazards before handing off to execute.
module operand_fetch #(
  parameter  int unsigned CNT_W = 32,
  localparam int unsigned XLEN  = 32,
  localparam int unsigned RA_W  = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic [XLEN-1:0]  i_pc,
  input  logic [XLEN-1:0]  i_instr,
  input  logic             i_flush,
  output logic             rf_enable,
  output logic [RA_W-1:0]  rf_rdaddress_a,
  output logic [RA_W-1:0]  rf_rdaddress_b,
  input  logic [XLEN-1:0]  rf_qa,
  input  logic [XLEN-1:0]  rf_qb,
  input  logic             fwd1_valid,
  input  logic [RA_W-1:0]  fwd1_wraddress,
  input  logic             fwd1_ready,
  input  logic [XLEN-1:0]  fwd1_data,
  input  logic             fwd2_valid,
  input  logic [RA_W-1:0]  fwd2_wraddress,
  input  logic [XLEN-1:0]  fwd2_data,
  input  logic             wb_wren,
  input  logic [RA_W-1:0]  wb_wraddress,
  input  logic [XLEN-1:0]  wb_data,
  output logic             o_valid,
  output logic [XLEN-1:0]  o_pc,
  output logic [XLEN-1:0]  o_instr,
  output logic [XLEN-1:0]  o_op_a,
  output logic [XLEN-1:0]  o_op_b,
  output logic             o_stall,
  output logic [CNT_W-1:0] o_stall_count
);

  // Hold register D
  logic            d_valid_q, d_valid_d;
  logic [XLEN-1:0] d_pc_q, d_pc_d;
  logic [XLEN-1:0] d_instr_q, d_instr_d;

  // Delayed write record W: write-back that commits on the same edge as the RF read sample
  logic            w_wren_q;
  logic [RA_W-1:0] w_addr_q;
  logic [XLEN-1:0] w_data_q;

  // Output register
  logic             o_valid_q, o_valid_d;
  logic [XLEN-1:0]  o_pc_q, o_pc_d;
  logic [XLEN-1:0]  o_instr_q, o_instr_d;
  logic [XLEN-1:0]  o_op_a_q, o_op_a_d;
  logic [XLEN-1:0]  o_op_b_q, o_op_b_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic [RA_W-1:0] rs, rt;
  logic            stall;
  logic            accept;
  logic [XLEN-1:0] rd_instr;
  logic [XLEN-1:0] op_a, op_b;

  assign rs = d_instr_q[25:21];
  assign rt = d_instr_q[20:16];

  // Only a non-final EX result (a load) can force a stall; r0 never depends on anything
  assign stall = d_valid_q && fwd1_valid && !fwd1_ready && (fwd1_wraddress != '0) &&
                 ((fwd1_wraddress == rs) || (fwd1_wraddress == rt));

  assign i_ready  = !stall;
  assign accept   = i_valid && !stall;
  assign rd_instr = accept ? i_instr : d_instr_q;

  assign rf_enable      = 1'b1;
  assign rf_rdaddress_a = rd_instr[25:21];
  assign rf_rdaddress_b = rd_instr[20:16];

  function automatic logic [XLEN-1:0] resolve(input logic [RA_W-1:0] ra,
                                              input logic [XLEN-1:0] rf_q);
    if (ra == '0)                                  return '0;
    else if (fwd1_valid && fwd1_wraddress == ra)   return fwd1_data;
    else if (fwd2_valid && fwd2_wraddress == ra)   return fwd2_data;
    else if (wb_wren && wb_wraddress == ra)        return wb_data;
    else if (w_wren_q && w_addr_q == ra)           return w_data_q;
    else                                           return rf_q;
  endfunction

  always_comb begin
    op_a = resolve(rs, rf_qa);
    op_b = resolve(rt, rf_qb);
  end

  // Next-state for D and the output register; flush outranks stall outranks advance
  always_comb begin
    d_valid_d   = d_valid_q;
    d_pc_d      = d_pc_q;
    d_instr_d   = d_instr_q;
    o_valid_d   = o_valid_q;
    o_pc_d      = o_pc_q;
    o_instr_d   = o_instr_q;
    o_op_a_d    = o_op_a_q;
    o_op_b_d    = o_op_b_q;
    stall_cnt_d = stall_cnt_q;

    if (i_flush) begin
      d_valid_d = 1'b0;
      o_valid_d = 1'b0;
    end else if (stall) begin
      o_valid_d   = 1'b0;
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      o_valid_d = d_valid_q;
      o_pc_d    = d_pc_q;
      o_instr_d = d_instr_q;
      o_op_a_d  = op_a;
      o_op_b_d  = op_b;
      d_valid_d = accept;
      if (accept) begin
        d_pc_d    = i_pc;
        d_instr_d = i_instr;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      d_valid_q   <= 1'b0;
      d_pc_q      <= '0;
      d_instr_q   <= '0;
      w_wren_q    <= 1'b0;
      w_addr_q    <= '0;
      w_data_q    <= '0;
      o_valid_q   <= 1'b0;
      o_pc_q      <= '0;
      o_instr_q   <= '0;
      o_op_a_q    <= '0;
      o_op_b_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      d_valid_q   <= d_valid_d;
      d_pc_q      <= d_pc_d;
      d_instr_q   <= d_instr_d;
      w_wren_q    <= wb_wren;
      w_addr_q    <= wb_wraddress;
      w_data_q    <= wb_data;
      o_valid_q   <= o_valid_d;
      o_pc_q      <= o_pc_d;
      o_instr_q   <= o_instr_d;
      o_op_a_q    <= o_op_a_d;
      o_op_b_q    <= o_op_b_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign o_valid       = o_valid_q;
  assign o_pc          = o_pc_q;
  assign o_instr       = o_instr_q;
  assign o_op_a        = o_op_a_q;
  assign o_op_b        = o_op_b_q;
  assign o_stall       = stall;
  assign o_stall_count = stall_cnt_q;

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Operand-fetch stage of the integer pipeline. It sits directly upstream of the register file: it drives the two register-file read addresses, captures the one-cycle-delayed read data, and resolves read-after-write hazards. Hazards are resolved by forwarding from the execute, memory and write-back stages, or by stalling on a load-use dependency. Its output register feeds the execute stage with the PC, the instruction and both resolved operands.

## Interface
- `CNT_W`, default 32: width of the stall performance counter.

Ports (`name  direction  width  meaning`):
- `clock`  in  1  single clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `i_valid`  in  1  upstream offers an instruction.
- `i_ready`  out  1  stage accepts the instruction this cycle.
- `i_pc`  in  32  PC of the offered instruction.
- `i_instr`  in  32  offered instruction word; rs = [25:21], rt = [20:16].
- `i_flush`  in  1  kill the held instruction and the output.
- `rf_enable`  out  1  register-file enable; constant 1.
- `rf_rdaddress_a`, `rf_rdaddress_b`  out  5  register-file read addresses.
- `rf_qa`, `rf_qb`  in  32  register-file read data, one cycle after the address.
- `fwd1_valid`  in  1  execute stage will write a register.
- `fwd1_wraddress`  in  5  execute stage destination register.
- `fwd1_ready`  in  1  `fwd1_data` is final; 0 for a load.
- `fwd1_data`  in  32  execute stage result.
- `fwd2_valid`, `fwd2_wraddress`, `fwd2_data`  in  1/5/32  memory stage result; always final.
- `wb_wren`, `wb_wraddress`, `wb_data`  in  1/5/32  write-back port; the same signals drive the register-file write port.
- `o_valid`  out  1  output register holds a valid instruction.
- `o_pc`, `o_instr`  out  32  output PC and instruction.
- `o_op_a`, `o_op_b`  out  32  resolved rs and rt values.
- `o_stall`  out  1  load-use stall active this cycle.
- `o_stall_count`  out  CNT_W  number of stall cycles since reset; wraps.

## Operation
- Hold register D contains `d_valid`, `d_pc` and `d_instr`. Accept when `i_valid && i_ready`.
- Read addresses: `rf_rdaddress_a` = rs of (accept ? `i_instr` : `d_instr`); `rf_rdaddress_b` is the same for rt. Reissuing the address on a stall re-reads the register file every cycle.
- Delayed write record W holds `w_wren`, `w_addr`, `w_data`. It is loaded every cycle from the `wb_*` inputs. It covers the write that commits on the same edge as the register-file read sample.
- Operand resolution for each of rs and rt while D is valid, highest priority first:
  - register 0 -> 0;
  - `fwd1_valid` and address match -> `fwd1_data`;
  - `fwd2_valid` and match -> `fwd2_data`;
  - `wb_wren` and match -> `wb_data`;
  - `w_wren` and match -> `w_data`;
  - else `rf_qa` or `rf_qb`.
- Stall: `stall = d_valid && fwd1_valid && !fwd1_ready && fwd1_wraddress != 0 && fwd1_wraddress in {rs, rt}`.
  - `i_ready = !stall`.
  - While stalled, D holds its contents, `o_valid` is loaded with 0 (a bubble) and `o_stall_count` increments.
- No stall: the output register loads `d_valid`, `d_pc`, `d_instr` and both resolved operands. D loads the accepted instruction, or `d_valid` goes to 0 if nothing is accepted.
- Flush: the next edge clears `d_valid` and `o_valid`. Flush overrides stall and accept. `i_ready` is still reported as `!stall`, but an instruction offered in a flush cycle is dropped. `o_stall_count` does not increment in a flush cycle.
- Reset: `d_valid`, `o_valid`, `w_wren` = 0; `o_pc`, `o_instr`, `o_op_a`, `o_op_b`, `o_stall_count` = 0. `o_stall` = 0 while `d_valid` = 0. Reset overrides flush.

## Timing
- Latency is 2 cycles from accept to `o_valid`: accept at edge E, D valid for the cycle after E, output valid after E+1.
- Throughput is 1 instruction per cycle with no hazards.
- Each load-use dependency adds one bubble per cycle that `fwd1_ready` = 0 with a match. The stall releases in the first cycle the match is gone or `fwd1_ready` = 1.
- `o_stall` and `i_ready` are combinational from D and the `fwd1_*` inputs. No combinational path exists from `i_valid` to `i_ready`.
- rs = rt is legal: both operands resolve identically.
- `o_stall_count` wraps from 2^CNT_W−1 to 0.

## Test plan
- Independent stream: r5 = 0x11, r6 = 0x22 preloaded via the `wb_*` port; instructions with rs=5, rt=6 issued back-to-back -> each `o_valid` two cycles after accept; `o_op_a`/`o_op_b` = 0x11/0x22; `o_stall` never asserted.
- Forwarding priority: rs=7 with fwd1 (r7 = 0xA), fwd2 (r7 = 0xB) and wb (r7 = 0xC) all valid -> `o_op_a` = 0xA. Drop fwd1 -> 0xB. Drop fwd2 -> 0xC.
- Delayed write: `wb_wren` r9 = 0x55 on the same edge that samples the register-file read of r9 -> `o_op_a` = 0x55, not the stale value.
- Load-use: fwd1 = load to r3, `fwd1_ready` = 0 for 2 cycles, consumer has rt=3 -> 2 bubbles, `o_stall_count` = 2. When `fwd1_ready` = 1 with data 0x77, `o_op_b` = 0x77.
- Register 0: fwd1 valid, address 0, data 0xFFFF_FFFF, `fwd1_ready` = 0, consumer rs=0 -> no stall, `o_op_a` = 0.
- Flush during stall, then reset mid-stream: flush -> `o_valid` = 0 and D empty next cycle. Reset -> all outputs 0 the cycle after reset is sampled high.
